// File: rtl/mem_responder_if.sv
// Cache-to-RAM request bus: addr/data/MemRead/MemWrite from the cache,
// data/ready pulse back. Master = cache controller, slave = memory.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cache2mem_addr;
  logic [DATA_W-1:0] cache2mem_data;
  logic              cache2mem_MemRead;
  logic              cache2mem_MemWrite;
  logic [DATA_W-1:0] mem2cache_data;
  logic              mem2cache_ready;

  modport master (
    output cache2mem_addr,
    output cache2mem_data,
    output cache2mem_MemRead,
    output cache2mem_MemWrite,
    input  mem2cache_data,
    input  mem2cache_ready
  );

  modport slave (
    input  cache2mem_addr,
    input  cache2mem_data,
    input  cache2mem_MemRead,
    input  cache2mem_MemWrite,
    output mem2cache_data,
    output mem2cache_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word RAM responder for the cache request bus.
// Ports: iCLK, iRST (async high), bus (slave), busy, proto_err, rd/wr_count.
module mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  mem_responder_if.slave   bus,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic [DEPTH_W-1:0] idx;
  logic [DATA_W-1:0]  wdata;
  logic               op_wr;
  logic [DATA_W-1:0]  rdata;
  logic               ready;

  logic [DATA_W-1:0]  ram [2**DEPTH_W];

  logic req;
  assign req = bus.cache2mem_MemRead | bus.cache2mem_MemWrite;

  logic unused_addr;
  assign unused_addr = ^{bus.cache2mem_addr[ADDR_W-1:DEPTH_W+2],
                         bus.cache2mem_addr[1:0]};

  assign bus.mem2cache_data  = rdata;
  assign bus.mem2cache_ready = ready;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      wdata     <= '0;
      op_wr     <= 1'b0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            idx   <= bus.cache2mem_addr[DEPTH_W+1:2];
            wdata <= bus.cache2mem_data;
            // Write wins when both are raised
            op_wr <= bus.cache2mem_MemWrite;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= WAIT;
            if (bus.cache2mem_MemRead && bus.cache2mem_MemWrite)
              proto_err <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            ready <= 1'b1;
            state <= RESP;
            if (!op_wr)
              rdata <= ram[idx];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (op_wr) begin
            if (wr_count != '1)
              wr_count <= wr_count + 1'b1;
          end else begin
            if (rd_count != '1)
              rd_count <= rd_count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; a reset forces IDLE so no pending write lands.
  always_ff @(posedge iCLK) begin
    if (!iRST && state == RESP && op_wr)
      ram[idx] <= wdata;
  end

endmodule
